// File: rtl/pad_line_mux.sv
// Shared pad line multiplexer: N macros share one pad line, with a parked guard window on every switch.
// Optional PAD_IN_SYNC_EN adds a 2-flop synchroniser on pad_i before it is gated to the macros.
module pad_line_mux #(
    parameter int N_MACRO = 4,
    parameter int WIDTH   = 10,
    parameter int GUARD   = 4,
    localparam int SEL_W  = (N_MACRO > 1) ? $clog2(N_MACRO) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           cfg_sel,
    input  logic                       cfg_load,
    output logic                       cfg_busy,
    output logic                       cfg_err,
    output logic [SEL_W-1:0]           cur_sel,
    input  logic [N_MACRO*WIDTH-1:0]   mac_o,
    input  logic [N_MACRO*WIDTH-1:0]   mac_oe,
    output logic [WIDTH-1:0]           pad_o,
    output logic [WIDTH-1:0]           pad_oe,
    input  logic [WIDTH-1:0]           pad_i,
    output logic [N_MACRO*WIDTH-1:0]   mac_i
);

    localparam logic ACTIVE = 1'b0;
    localparam logic PARK   = 1'b1;

    logic               state;
    logic [SEL_W-1:0]   pending;
    logic [7:0]         cnt;
    logic [SEL_W:0]     sel_ext;
    logic               in_range;
    logic               accept;
    logic               reject;
    logic [WIDTH-1:0]   sel_o;
    logic [WIDTH-1:0]   sel_oe;
    logic [WIDTH-1:0]   pin;

    assign sel_ext  = {1'b0, cfg_sel};
    assign in_range = sel_ext < (SEL_W+1)'(N_MACRO);
    assign accept   = cfg_load && (state == ACTIVE) && in_range
                      && (cfg_sel != cur_sel);
    assign reject   = cfg_load && (!in_range || (state == PARK));
    assign cfg_busy = (state == PARK);

    // Switch FSM: accept a new macro, park for GUARD cycles, then connect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACTIVE;
            cur_sel <= '0;
            pending <= '0;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= reject;
            unique case (state)
                ACTIVE: begin
                    if (accept) begin
                        pending <= cfg_sel;
                        cnt     <= 8'(GUARD - 1);
                        state   <= PARK;
                    end
                end
                PARK: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        cur_sel <= pending;
                        state   <= ACTIVE;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    // Pick the connected macro's output data and enables.
    always_comb begin
        sel_o  = '0;
        sel_oe = '0;
        for (int m = 0; m < N_MACRO; m++) begin
            if (cur_sel == SEL_W'(m)) begin
                sel_o  = mac_o[m*WIDTH +: WIDTH];
                sel_oe = mac_oe[m*WIDTH +: WIDTH];
            end
        end
    end

    // Register pad outputs; enables drop as soon as a switch is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_o  <= '0;
            pad_oe <= '0;
        end else if ((state == ACTIVE) && !accept) begin
            pad_o  <= sel_o;
            pad_oe <= sel_oe;
        end else begin
            pad_oe <= '0;
        end
    end

`ifdef PAD_IN_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pad_i;
            sync2 <= sync1;
        end
    end

    assign pin = sync2;
`else
    assign pin = pad_i;
`endif

    // Route pad input only to the connected macro, and to nobody while parked.
    always_comb begin
        mac_i = '0;
        if (state == ACTIVE) begin
            for (int m = 0; m < N_MACRO; m++) begin
                if (cur_sel == SEL_W'(m)) begin
                    mac_i[m*WIDTH +: WIDTH] = pin;
                end
            end
        end
    end

endmodule
